// File: rtl/spi_tft_screen_receiver_if.sv
// Panel-side TFT link: the 4-wire SPI inputs plus the decoded command/pixel stream.
// The master modport is the screen driver / capture side, the slave modport is the receiver.
interface spi_tft_screen_receiver_if;
  logic        spi_sclk_i;
  logic        spi_mosi_i;
  logic        spi_cs_i;
  logic        lcd_dc_i;
  logic        cmd_valid_o;
  logic [7:0]  cmd_byte_o;
  logic        frame_start_o;
  logic        pixel_valid_o;
  logic [15:0] pixel_data_o;
  logic [15:0] pixel_x_o;
  logic [15:0] pixel_y_o;

  modport master (
    output spi_sclk_i, spi_mosi_i, spi_cs_i, lcd_dc_i,
    input  cmd_valid_o, cmd_byte_o, frame_start_o,
    input  pixel_valid_o, pixel_data_o, pixel_x_o, pixel_y_o
  );

  modport slave (
    input  spi_sclk_i, spi_mosi_i, spi_cs_i, lcd_dc_i,
    output cmd_valid_o, cmd_byte_o, frame_start_o,
    output pixel_valid_o, pixel_data_o, pixel_x_o, pixel_y_o
  );
endinterface

// File: rtl/spi_tft_screen_receiver.sv
// SPI mode-0 slave emulating a TFT panel: decodes command/data bytes, tracks the
// CASET/RASET window and emits RGB565 pixels tagged with x/y during RAMWR.
module spi_tft_screen_receiver #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  spi_tft_screen_receiver_if.slave    bus_io
);

  localparam logic [15:0] XE_RST = 16'(SCREEN_WIDTH - 1);
  localparam logic [15:0] YE_RST = 16'(SCREEN_HEIGHT - 1);
  // Synchroniser lanes: {dc, cs, mosi, sclk}; cs idles high.
  localparam logic [3:0]  SYNC_RST = 4'b0100;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_RASET,
    S_RAMWR,
    S_OTHER
  } state_t;

  logic [3:0]  sync1_q, sync2_q;
  logic        sclk_prev_q;
  logic        rise_p0_q, mosi_p0_q, cs_p0_q, dc_p0_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shift_q;
  logic [7:0]  byte_d;
  logic        byte_vld_p1_q;
  logic [7:0]  byte_p1_q;
  logic        dc_p1_q;

  state_t      state_q;
  logic [2:0]  idx_q;
  logic        pend_q;
  logic [7:0]  pend_byte_q;
  logic [15:0] xs_q, xe_q, ys_q, ye_q;
  logic [15:0] x_q, y_q;
  logic [15:0] x_d, y_d;

  logic        cmd_valid_q;
  logic [7:0]  cmd_byte_q;
  logic        frame_start_q;
  logic        pixel_valid_q;
  logic [15:0] pixel_data_q, pixel_x_q, pixel_y_q;

  assign byte_d = {shift_q, mosi_p0_q};

  // Stage p0: synchronise the link and register the sclk rising edge with its data.
  // Stage p1: assemble bytes; cs high drops any partial byte.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q       <= SYNC_RST;
      sync2_q       <= SYNC_RST;
      sclk_prev_q   <= 1'b0;
      rise_p0_q     <= 1'b0;
      mosi_p0_q     <= 1'b0;
      cs_p0_q       <= 1'b1;
      dc_p0_q       <= 1'b0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 7'd0;
      byte_vld_p1_q <= 1'b0;
      byte_p1_q     <= 8'd0;
      dc_p1_q       <= 1'b0;
    end else begin
      sync1_q       <= {bus_io.lcd_dc_i, bus_io.spi_cs_i, bus_io.spi_mosi_i, bus_io.spi_sclk_i};
      sync2_q       <= sync1_q;
      sclk_prev_q   <= sync2_q[0];
      rise_p0_q     <= sync2_q[0] & ~sclk_prev_q;
      mosi_p0_q     <= sync2_q[1];
      cs_p0_q       <= sync2_q[2];
      dc_p0_q       <= sync2_q[3];
      byte_vld_p1_q <= 1'b0;
      if (cs_p0_q) begin
        bit_cnt_q <= 3'd0;
        shift_q   <= 7'd0;
      end else if (rise_p0_q) begin
        shift_q   <= byte_d[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_vld_p1_q <= 1'b1;
          byte_p1_q     <= byte_d;
          dc_p1_q       <= dc_p0_q;
        end
      end
    end
  end

  // Raster advance inside the window; a reversed window collapses to XS / YS.
  always_comb begin
    x_d = x_q + 16'd1;
    y_d = y_q;
    if (x_q >= xe_q) begin
      x_d = xs_q;
      y_d = (y_q >= ye_q) ? ys_q : (y_q + 16'd1);
    end
  end

  // Stage p2: command/data decode and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= 3'd0;
      pend_q        <= 1'b0;
      pend_byte_q   <= 8'd0;
      xs_q          <= 16'd0;
      xe_q          <= XE_RST;
      ys_q          <= 16'd0;
      ye_q          <= YE_RST;
      x_q           <= 16'd0;
      y_q           <= 16'd0;
      cmd_valid_q   <= 1'b0;
      cmd_byte_q    <= 8'd0;
      frame_start_q <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= 16'd0;
      pixel_x_q     <= 16'd0;
      pixel_y_q     <= 16'd0;
    end else begin
      cmd_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_valid_q <= 1'b0;
      if (byte_vld_p1_q && !dc_p1_q) begin
        cmd_valid_q <= 1'b1;
        cmd_byte_q  <= byte_p1_q;
        idx_q       <= 3'd0;
        pend_q      <= 1'b0;
        case (byte_p1_q)
          CMD_CASET: state_q <= S_CASET;
          CMD_RASET: state_q <= S_RASET;
          CMD_RAMWR: begin
            state_q       <= S_RAMWR;
            frame_start_q <= 1'b1;
            x_q           <= xs_q;
            y_q           <= ys_q;
          end
          default:   state_q <= S_OTHER;
        endcase
      end else if (byte_vld_p1_q) begin
        case (state_q)
          S_CASET, S_RASET: begin
            // Index saturates at 4 so trailing parameter bytes are ignored.
            if (idx_q != 3'd4) idx_q <= idx_q + 3'd1;
            case ({state_q == S_RASET, idx_q})
              4'b0_000: xs_q[15:8] <= byte_p1_q;
              4'b0_001: xs_q[7:0]  <= byte_p1_q;
              4'b0_010: xe_q[15:8] <= byte_p1_q;
              4'b0_011: xe_q[7:0]  <= byte_p1_q;
              4'b1_000: ys_q[15:8] <= byte_p1_q;
              4'b1_001: ys_q[7:0]  <= byte_p1_q;
              4'b1_010: ye_q[15:8] <= byte_p1_q;
              4'b1_011: ye_q[7:0]  <= byte_p1_q;
              default: ;
            endcase
          end
          S_RAMWR: begin
            if (!pend_q) begin
              pend_q      <= 1'b1;
              pend_byte_q <= byte_p1_q;
            end else begin
              pend_q        <= 1'b0;
              pixel_valid_q <= 1'b1;
              pixel_data_q  <= {pend_byte_q, byte_p1_q};
              pixel_x_q     <= x_q;
              pixel_y_q     <= y_q;
              x_q           <= x_d;
              y_q           <= y_d;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus_io.cmd_valid_o   = cmd_valid_q;
  assign bus_io.cmd_byte_o    = cmd_byte_q;
  assign bus_io.frame_start_o = frame_start_q;
  assign bus_io.pixel_valid_o = pixel_valid_q;
  assign bus_io.pixel_data_o  = pixel_data_q;
  assign bus_io.pixel_x_o     = pixel_x_q;
  assign bus_io.pixel_y_o     = pixel_y_q;

endmodule
